// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, defaults and saturating arithmetic for the FC argmax engine
//
// Contents:
//   ACC_W_DEF  : default signed accumulator/result width
//   fc_state_e : engine FSM states (IDLE -> RUN -> DRAIN -> DONE -> IDLE)
//   sat_add    : add two signed values and clamp the sum to a signed w-bit range
package fc_pkg;

    localparam int ACC_W_DEF = 21;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fc_state_e;

    // Operands are carried at 64 bits so the raw sum cannot wrap for any
    // practical w; the result is clamped to [-2^(w-1), 2^(w-1)-1].
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/fc_argmax_engine_mac.sv
// rtl/fc_argmax_engine_mac.sv - combinational LANES-wide multiply and sum for one beat
//
// Module fc_mac_lanes
//   i_fm_data : LANES unsigned D_W-bit feature-map elements, lane 0 in LSBs
//   i_weight  : LANES signed W_W-bit weights, lane 0 in LSBs
//   o_sum     : exact signed sum of all lane products (SUM_W bits, never overflows)
module fc_mac_lanes #(
    parameter int LANES = 8,
    parameter int D_W   = 8,
    parameter int W_W   = 4,
    parameter int SUM_W = D_W + W_W + 1 + $clog2(LANES)
) (
    input  logic [LANES*D_W-1:0]    i_fm_data,
    input  logic [LANES*W_W-1:0]    i_weight,
    output logic signed [SUM_W-1:0] o_sum
);

    // Unsigned fm gains a zero sign bit so the product is a plain signed multiply.
    localparam int PROD_W = D_W + W_W + 1;

    logic signed [PROD_W-1:0] fm_ext;
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;

    always_comb begin
        fm_ext = '0;
        w_ext  = '0;
        prod   = '0;
        sum    = '0;
        for (int l = 0; l < LANES; l++) begin
            fm_ext = PROD_W'($signed({1'b0, i_fm_data[l*D_W +: D_W]}));
            w_ext  = PROD_W'($signed(i_weight[l*W_W +: W_W]));
            prod   = fm_ext * w_ext;
            sum    = sum + SUM_W'(prod);
        end
        o_sum = sum;
    end

endmodule

// File: rtl/fc_argmax_engine.sv
// rtl/fc_argmax_engine.sv - fully-connected layer with saturating MAC and running argmax
//
// Streams N_OUT*BEATS beats from two 1-cycle-latency memories (fm reused per
// neuron, weights contiguous per neuron), accumulates each neuron with
// saturation and keeps the index/value of the largest neuron.
// Optional macro FC_BIAS_EN adds a per-neuron bias port pair.
//
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   i_start                          : start pulse (ignored while o_busy)
//   i_fm_base_addr, i_w_base_addr    : base addresses latched on start
//   o_fm_addr, o_w_addr, o_rd_en     : memory read request (RUN only)
//   i_fm_data, i_weight              : read data, valid the cycle after o_rd_en
//   i_bias, o_bias_idx               : bias lookup (FC_BIAS_EN only)
//   o_busy, o_done                   : run status, one-cycle completion pulse
//   o_class, o_max_val               : argmax result, held until next o_done
module fc_argmax_engine
    import fc_pkg::*;
#(
    parameter int  LANES  = 8,
    parameter int  IN_LEN = 384,
    parameter int  N_OUT  = 27,
    parameter int  D_W    = 8,
    parameter int  W_W    = 4,
    parameter int  ACC_W  = ACC_W_DEF,
    parameter int  ADDR_W = 16,
    localparam int CLS_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [ADDR_W-1:0]       i_fm_base_addr,
    input  logic [ADDR_W-1:0]       i_w_base_addr,
    output logic [ADDR_W-1:0]       o_fm_addr,
    output logic [ADDR_W-1:0]       o_w_addr,
    output logic                    o_rd_en,
    input  logic [LANES*D_W-1:0]    i_fm_data,
    input  logic [LANES*W_W-1:0]    i_weight,
`ifdef FC_BIAS_EN
    input  logic signed [ACC_W-1:0] i_bias,
    output logic [CLS_W-1:0]        o_bias_idx,
`endif
    output logic                    o_busy,
    output logic                    o_done,
    output logic [CLS_W-1:0]        o_class,
    output logic signed [ACC_W-1:0] o_max_val
);

    localparam int BEATS  = IN_LEN / LANES;
    localparam int TOTAL  = N_OUT * BEATS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam int SUM_W  = D_W + W_W + 1 + $clog2(LANES);

    fc_state_e state_q, state_d;

    logic [ADDR_W-1:0]       fm_base_q, fm_base_d;
    logic [ADDR_W-1:0]       w_base_q, w_base_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [CLS_W-1:0]        neuron_q, neuron_d;
    // Reads issued so far; equals neuron*BEATS+beat, i.e. the weight offset.
    logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;

    // Tags travelling alongside the read so they line up with returning data.
    logic                    rsp_vld_q, rsp_vld_d;
    logic                    rsp_last_q, rsp_last_d;
    logic [CLS_W-1:0]        rsp_neuron_q, rsp_neuron_d;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] max_val_q, max_val_d;
    logic [CLS_W-1:0]        max_idx_q, max_idx_d;

    logic                    done_q, done_d;
    logic [CLS_W-1:0]        class_q, class_d;
    logic signed [ACC_W-1:0] result_q, result_d;

    logic                    rd_en;
    logic signed [SUM_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] bias_val;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] neuron_val;

    fc_mac_lanes #(
        .LANES (LANES),
        .D_W   (D_W),
        .W_W   (W_W),
        .SUM_W (SUM_W)
    ) u_mac (
        .i_fm_data (i_fm_data),
        .i_weight  (i_weight),
        .o_sum     (beat_sum)
    );

`ifdef FC_BIAS_EN
    assign bias_val   = i_bias;
    assign o_bias_idx = rsp_neuron_q;
`else
    assign bias_val   = '0;
`endif

    always_comb begin
        state_d      = state_q;
        fm_base_d    = fm_base_q;
        w_base_d     = w_base_q;
        beat_d       = beat_q;
        neuron_d     = neuron_q;
        rd_cnt_d     = rd_cnt_q;
        rsp_vld_d    = 1'b0;
        rsp_last_d   = 1'b0;
        rsp_neuron_d = rsp_neuron_q;
        acc_d        = acc_q;
        max_val_d    = max_val_q;
        max_idx_d    = max_idx_q;
        done_d       = 1'b0;
        class_d      = class_q;
        result_d     = result_q;
        rd_en        = 1'b0;

        acc_sum    = ACC_W'(sat_add(64'(acc_q), 64'(beat_sum), ACC_W));
        neuron_val = ACC_W'(sat_add(64'(acc_sum), 64'(bias_val), ACC_W));

        case (state_q)
            ST_IDLE: begin
                // done_q still high means o_busy is asserted: start is ignored.
                if (i_start && !done_q) begin
                    fm_base_d = i_fm_base_addr;
                    w_base_d  = i_w_base_addr;
                    beat_d    = '0;
                    neuron_d  = '0;
                    rd_cnt_d  = '0;
                    acc_d     = '0;
                    max_val_d = '0;
                    max_idx_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en        = 1'b1;
                rsp_vld_d    = 1'b1;
                rsp_last_d   = (beat_q == BEAT_W'(BEATS - 1));
                rsp_neuron_d = neuron_q;
                rd_cnt_d     = rd_cnt_q + CNT_W'(1);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d   = '0;
                    neuron_d = neuron_q + CLS_W'(1);
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (rd_cnt_q == CNT_W'(TOTAL - 1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d   = 1'b1;
                class_d  = max_idx_q;
                result_d = max_val_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Returning beat: accumulate, and on a neuron's last beat fold in
        // the bias and update the running max (strict > keeps lower index).
        if (rsp_vld_q) begin
            if (rsp_last_q) begin
                acc_d = '0;
                if ((rsp_neuron_q == '0) || (neuron_val > max_val_q)) begin
                    max_val_d = neuron_val;
                    max_idx_d = rsp_neuron_q;
                end
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fm_base_q    <= '0;
            w_base_q     <= '0;
            beat_q       <= '0;
            neuron_q     <= '0;
            rd_cnt_q     <= '0;
            rsp_vld_q    <= 1'b0;
            rsp_last_q   <= 1'b0;
            rsp_neuron_q <= '0;
            acc_q        <= '0;
            max_val_q    <= '0;
            max_idx_q    <= '0;
            done_q       <= 1'b0;
            class_q      <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            fm_base_q    <= fm_base_d;
            w_base_q     <= w_base_d;
            beat_q       <= beat_d;
            neuron_q     <= neuron_d;
            rd_cnt_q     <= rd_cnt_d;
            rsp_vld_q    <= rsp_vld_d;
            rsp_last_q   <= rsp_last_d;
            rsp_neuron_q <= rsp_neuron_d;
            acc_q        <= acc_d;
            max_val_q    <= max_val_d;
            max_idx_q    <= max_idx_d;
            done_q       <= done_d;
            class_q      <= class_d;
            result_q     <= result_d;
        end
    end

    // Addresses are forced to zero whenever no read is being issued.
    assign o_rd_en   = rd_en;
    assign o_fm_addr = rd_en ? (fm_base_q + ADDR_W'(beat_q)) : '0;
    assign o_w_addr  = rd_en ? (w_base_q + ADDR_W'(rd_cnt_q)) : '0;
    assign o_busy    = (state_q != ST_IDLE) || done_q;
    assign o_done    = done_q;
    assign o_class   = class_q;
    assign o_max_val = result_q;

endmodule

// File: tb/tb_fc_argmax_engine.sv
// tb/tb_fc_argmax_engine.sv - self-checking bench for fc_argmax_engine
module tb_fc_argmax_engine;

    localparam int LANES    = 8;
    localparam int IN_LEN   = 16;
    localparam int N_OUT    = 4;
    localparam int D_W      = 8;
    localparam int W_W      = 4;
    localparam int ACC_W    = 21;
    localparam int ADDR_W   = 16;
    localparam int CLS_W    = 2;
    localparam int BEATS    = IN_LEN / LANES;
    localparam int TOTAL    = N_OUT * BEATS;
    localparam int DONE_LAT = TOTAL + 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    i_start = 1'b0;
    logic [ADDR_W-1:0]       i_fm_base_addr = '0;
    logic [ADDR_W-1:0]       i_w_base_addr = '0;
    logic [ADDR_W-1:0]       o_fm_addr;
    logic [ADDR_W-1:0]       o_w_addr;
    logic                    o_rd_en;
    logic [LANES*D_W-1:0]    i_fm_data = '0;
    logic [LANES*W_W-1:0]    i_weight = '0;
    logic                    o_busy;
    logic                    o_done;
    logic [CLS_W-1:0]        o_class;
    logic signed [ACC_W-1:0] o_max_val;
    logic [CLS_W-1:0]        bias_idx_tb;

    logic [LANES*D_W-1:0]    fm_mem [2**ADDR_W];
    logic [LANES*W_W-1:0]    w_mem [2**ADDR_W];
    logic signed [ACC_W-1:0] bias_tab [N_OUT];
    logic [ADDR_W-1:0]       fm_base;
    logic [ADDR_W-1:0]       w_base;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FC_BIAS_EN
    logic signed [ACC_W-1:0] i_bias;
    logic [CLS_W-1:0]        o_bias_idx;
    assign i_bias      = bias_tab[o_bias_idx];
    assign bias_idx_tb = o_bias_idx;
`else
    assign bias_idx_tb = '0;
`endif

    fc_argmax_engine #(
        .LANES  (LANES),
        .IN_LEN (IN_LEN),
        .N_OUT  (N_OUT),
        .D_W    (D_W),
        .W_W    (W_W),
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_fm_base_addr (i_fm_base_addr),
        .i_w_base_addr  (i_w_base_addr),
        .o_fm_addr      (o_fm_addr),
        .o_w_addr       (o_w_addr),
        .o_rd_en        (o_rd_en),
        .i_fm_data      (i_fm_data),
        .i_weight       (i_weight),
`ifdef FC_BIAS_EN
        .i_bias         (i_bias),
        .o_bias_idx     (o_bias_idx),
`endif
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_class        (o_class),
        .o_max_val      (o_max_val)
    );

    always #5 clk = ~clk;

    // 1-cycle latency memories
    always @(posedge clk) begin
        if (o_rd_en) begin
            i_fm_data <= fm_mem[o_fm_addr];
            i_weight  <= w_mem[o_w_addr];
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clip(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) << (ACC_W - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: dot product per neuron with per-beat saturation, bias, argmax.
    function automatic void model(output int cls, output longint mx);
        logic [LANES*D_W-1:0] fw;
        logic [LANES*W_W-1:0] ww;
        logic [W_W-1:0]       wn;
        longint acc;
        longint s;
        cls = 0;
        mx  = 0;
        for (int n = 0; n < N_OUT; n++) begin
            acc = 0;
            for (int b = 0; b < BEATS; b++) begin
                fw = fm_mem[ADDR_W'(fm_base + ADDR_W'(b))];
                ww = w_mem[ADDR_W'(w_base + ADDR_W'(n * BEATS + b))];
                s  = 0;
                for (int l = 0; l < LANES; l++) begin
                    wn = ww[l*W_W +: W_W];
                    s  = s + longint'(fw[l*D_W +: D_W]) * longint'($signed(wn));
                end
                acc = clip(acc + s);
            end
            acc = clip(acc + longint'(bias_tab[n]));
            if (n == 0 || acc > mx) begin
                mx  = acc;
                cls = n;
            end
        end
    endfunction

    task automatic fill_fm(input logic [D_W-1:0] v);
        for (int b = 0; b < BEATS; b++) fm_mem[ADDR_W'(fm_base + ADDR_W'(b))] = {LANES{v}};
    endtask

    task automatic set_w(input int n, input int b, input logic [W_W-1:0] v);
        w_mem[ADDR_W'(w_base + ADDR_W'(n * BEATS + b))] = {LANES{v}};
    endtask

    task automatic run_and_check(input string tag, input int repulse_at,
                                 input int exp_cls, input longint exp_max);
        int done_cyc;
        int n_done;
        int n_rd;
        bit busy_ok;
        bit addr_ok;
        done_cyc = -1;
        n_done   = 0;
        n_rd     = 0;
        busy_ok  = 1'b1;
        addr_ok  = 1'b1;
        @(posedge clk); #1;
        i_fm_base_addr = fm_base;
        i_w_base_addr  = w_base;
        i_start        = 1'b1;
        for (int cyc = 1; cyc <= DONE_LAT + 6; cyc++) begin
            @(posedge clk); #1;
            i_start = (cyc == repulse_at);
            if (o_rd_en) begin
                if (o_fm_addr !== ADDR_W'(fm_base + ADDR_W'((cyc - 1) % BEATS))) addr_ok = 1'b0;
                if (o_w_addr !== ADDR_W'(w_base + ADDR_W'(cyc - 1))) addr_ok = 1'b0;
                n_rd++;
            end
            if (o_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (o_busy !== (cyc <= DONE_LAT)) busy_ok = 1'b0;
        end
        i_start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, DONE_LAT);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_rd_count"}, n_rd, TOTAL);
        check({tag, "_addr"}, addr_ok, 1);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_class"}, o_class, exp_cls);
        check({tag, "_max_val"}, o_max_val, exp_max);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_rd_en"}, o_rd_en, 0);
        check({tag, "_class"}, o_class, 0);
        check({tag, "_max_val"}, o_max_val, 0);
        check({tag, "_fm_addr"}, o_fm_addr, 0);
        check({tag, "_w_addr"}, o_w_addr, 0);
        check({tag, "_bias_idx"}, bias_idx_tb, 0);
    endtask

    initial begin
        int     cls;
        longint mx;

        for (int n = 0; n < N_OUT; n++) bias_tab[n] = '0;
        fm_base = 16'h0100;
        w_base  = 16'h0200;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fm=1, neuron n weights all n
        fill_fm(8'd1);
        for (int n = 0; n < N_OUT; n++)
            for (int b = 0; b < BEATS; b++) set_w(n, b, W_W'(n));
        run_and_check("ramp", -1, 3, 48);

        // tie between neurons 1 and 2
        for (int n = 0; n < N_OUT; n++)
            for (int b = 0; b < BEATS; b++) set_w(n, b, '0);
        set_w(1, 0, 4'd5);
        set_w(2, 1, 4'd5);
        run_and_check("tie", -1, 1, 40);

        // all negative, identical neurons
        fill_fm(8'd255);
        for (int n = 0; n < N_OUT; n++)
            for (int b = 0; b < BEATS; b++) set_w(n, b, 4'h8);
        run_and_check("neg", -1, 0, -32640);

        // start re-pulsed during run is ignored
        fill_fm(8'd1);
        for (int n = 0; n < N_OUT; n++)
            for (int b = 0; b < BEATS; b++) set_w(n, b, W_W'(n));
        run_and_check("repulse", 4, 3, 48);

        // reset mid-run
        @(posedge clk); #1;
        i_fm_base_addr = fm_base;
        i_w_base_addr  = w_base;
        i_start        = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check("after_rst", -1, 3, 48);

`ifdef FC_BIAS_EN
        fill_fm(8'd0);
        bias_tab[0] = 5;
        bias_tab[1] = -1;
        bias_tab[2] = 9;
        bias_tab[3] = 9;
        run_and_check("bias", -1, 2, 9);
`endif

        for (int t = 0; t < 8; t++) begin
            fm_base = ADDR_W'($urandom_range(0, 65535));
            w_base  = ADDR_W'($urandom_range(0, 65535));
            for (int b = 0; b < BEATS; b++)
                fm_mem[ADDR_W'(fm_base + ADDR_W'(b))] = {$urandom(), $urandom()};
            for (int k = 0; k < TOTAL; k++)
                w_mem[ADDR_W'(w_base + ADDR_W'(k))] = $urandom();
`ifdef FC_BIAS_EN
            for (int n = 0; n < N_OUT; n++) bias_tab[n] = ACC_W'($signed($urandom_range(0, 4000)) - 2000);
`endif
            model(cls, mx);
            run_and_check($sformatf("rand%0d", t), -1, cls, mx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
